// File: rtl/fsm_pkg.sv
// Shared types for the "010" sequence detector, used by the RTL and by the bench.
`timescale 1ns/1ps
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZERO  = 2'd1,
        ONE   = 2'd2,
        STORE = 2'd3
    } state_e;

endpackage

// File: rtl/fsm_010.sv
// Moore detector for the serial pattern "010".
// It counts one detection for each edge that is taken while in STORE.
`timescale 1ns/1ps
module fsm_010
    import fsm_pkg::*;
#(
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x,
    output logic                   y,
    output logic [COUNT_WIDTH-1:0] users_count
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = x ? IDLE : ZERO;
            ZERO:    state_d = x ? ONE  : ZERO;
            ONE:     state_d = x ? IDLE : STORE;
            STORE:   state_d = x ? IDLE : ZERO;
            default: state_d = IDLE;
        endcase
    end

    assign y = (state_q == STORE);

    // The count lags y by one edge and wraps freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            users_count <= '0;
        end else if (state_q == STORE) begin
            users_count <= users_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fsm_010.sv
// Self-checking bench for fsm_010: vector table, reset/wrap sequences and a random run against a model.
`timescale 1ns/1ps
module tb_fsm_010;
    import fsm_pkg::*;

    localparam int CW = 10;

    logic          clk;
    logic          rst;
    logic          x;
    logic          y;
    logic [CW-1:0] users_count;

    int total;
    int bad;

    typedef struct {
        logic          x;
        logic          exp_y;
        logic [CW-1:0] exp_count;
    } vec_t;

    vec_t vecs[23];

    state_e        model_state;
    logic [CW-1:0] model_count;

    fsm_010 #(.COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .y          (y),
        .users_count(users_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic applyStimulus(input logic xi, input logic ri);
        x   = xi;
        rst = ri;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic exp_y, input logic [CW-1:0] exp_cnt);
        total++;
        if (y !== exp_y || users_count !== exp_cnt) begin
            bad++;
            $display("[TB] FAIL %s: got y=%0b count=%0d, want y=%0b count=%0d",
                     name, y, users_count, exp_y, exp_cnt);
        end
    endtask

    function automatic state_e model_next(state_e s, logic xi);
        state_e n;
        n = IDLE;
        if (s == IDLE)       n = xi ? IDLE : ZERO;
        else if (s == ZERO)  n = xi ? ONE  : ZERO;
        else if (s == ONE)   n = xi ? IDLE : STORE;
        else                 n = xi ? IDLE : ZERO;
        return n;
    endfunction

    initial begin
        logic xr;
        logic rr;
        total = 0;
        bad   = 0;

        // x, y after the edge, users_count after the edge
        vecs[0]  = '{1'b0, 1'b0, 10'd0};
        vecs[1]  = '{1'b1, 1'b0, 10'd0};
        vecs[2]  = '{1'b0, 1'b1, 10'd0};
        vecs[3]  = '{1'b1, 1'b0, 10'd1};
        vecs[4]  = '{1'b0, 1'b0, 10'd1};
        vecs[5]  = '{1'b1, 1'b0, 10'd1};
        vecs[6]  = '{1'b0, 1'b1, 10'd1};
        vecs[7]  = '{1'b1, 1'b0, 10'd2};
        vecs[8]  = '{1'b0, 1'b0, 10'd2};
        vecs[9]  = '{1'b0, 1'b0, 10'd2};
        vecs[10] = '{1'b1, 1'b0, 10'd2};
        vecs[11] = '{1'b0, 1'b1, 10'd2};
        vecs[12] = '{1'b0, 1'b0, 10'd3};
        vecs[13] = '{1'b1, 1'b0, 10'd3};
        vecs[14] = '{1'b0, 1'b1, 10'd3};
        vecs[15] = '{1'b1, 1'b0, 10'd4};
        vecs[16] = '{1'b1, 1'b0, 10'd4};
        vecs[17] = '{1'b1, 1'b0, 10'd4};
        vecs[18] = '{1'b0, 1'b0, 10'd4};
        vecs[19] = '{1'b0, 1'b0, 10'd4};
        vecs[20] = '{1'b1, 1'b0, 10'd4};
        vecs[21] = '{1'b1, 1'b0, 10'd4};
        vecs[22] = '{1'b0, 1'b0, 10'd4};

        rst = 1'b0;
        x   = 1'b0;
        @(negedge clk);
        checkOutput("reset", 1'b0, 10'd0);
        @(negedge clk);
        checkOutput("reset_hold", 1'b0, 10'd0);

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].x, 1'b1);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_count);
        end

        // Async reset while sitting in STORE, away from any edge.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("pre_mid_reset", 1'b1, 10'd4);
        #2 rst = 1'b0;
        #1 checkOutput("mid_reset_async", 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_reset_hold", 1'b0, 10'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("post_reset_zero", 1'b0, 10'd0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("post_reset_store", 1'b1, 10'd0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("post_reset_count", 1'b0, 10'd1);

        // Reset just before the edge that would leave STORE must suppress the increment.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("store_again", 1'b1, 10'd1);
        #4 rst = 1'b0;
        x = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_at_edge", 1'b0, 10'd0);
        rst = 1'b1;

        // 1024 back-to-back "010" patterns wrap the counter to zero.
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("wrap_1023", 1'b1, 10'd1023);
        applyStimulus(1'b1, 1'b1);
        checkOutput("wrap_zero", 1'b0, 10'd0);

        model_state = IDLE;
        model_count = '0;
        for (int i = 0; i < 18000; i++) begin
            xr = 1'($urandom_range(0, 1));
            rr = (i < 9000) ? ($urandom_range(0, 15) != 0) : 1'b1;
            x   = xr;
            rst = rr;
            if (!rr) begin
                model_state = IDLE;
                model_count = '0;
            end
            @(posedge clk);
            if (rr) begin
                if (model_state == STORE) model_count = model_count + 10'd1;
                model_state = model_next(model_state, xr);
            end
            @(negedge clk);
            checkOutput($sformatf("rand%0d", i), (model_state == STORE), model_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
